micro_op_issue: RTL and testbench
=================================

Name: micro_op_issue

Overview:
- Upstream operand-fetch and issue stage for the 4-bit logic microoperation unit.
- Holds a small register file and accepts microoperation commands through a valid/ready handshake.
- For each command it drives the operands and the 2-bit op select to the logic unit, captures the unit's registered result, and writes the result back to a destination register.
- Also provides a host load port and a debug read port.

Parameters:
- WIDTH, 4, data width of registers and operands; must match the logic unit's data width.
- REGS, 4, number of registers in the file; must be a power of two.
- AW, log2(REGS) = 2, register address width; derived, not overridden.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clock.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0=AND, 1=OR, 2=XOR, 3=NOT A.
- cmd_src_a  in  AW  source register A.
- cmd_src_b  in  AW  source register B; ignored for op 3.
- cmd_dst  in  AW  destination register.
- wr_en  in  1  host register load strobe.
- wr_addr  in  AW  host load address.
- wr_data  in  WIDTH  host load data.
- rd_addr  in  AW  debug read address.
- rd_data  out  WIDTH  combinational rf[rd_addr].
- lu_select  out  2  to the logic unit's selective_set input.
- lu_a  out  WIDTH  to the logic unit's processor_register input.
- lu_b  out  WIDTH  to the logic unit's b_in input.
- lu_data  in  WIDTH  logic unit's registered result.
- done  out  1  one-cycle pulse when a write-back completes.
- result  out  WIDTH  value written on the most recent write-back; held until the next one.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE; all registers=0.
  - lu_select, lu_a, lu_b, done and result all =0.
  - An in-flight command is aborted with no write-back.
- States: IDLE, EXEC, WB.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid=1: lu_a<=rf[src_a], lu_b<=rf[src_b], lu_select<=cmd_op, latch dst, go to EXEC.
- EXEC:
  - lu_* outputs are stable.
  - The logic unit samples them at this edge; go to WB.
- WB:
  - lu_data is valid.
  - At the edge: rf[dst]<=lu_data, result<=lu_data, done<=1, go to IDLE.
- done is high for exactly the one cycle following the WB edge.
- Latency: accept edge to the done-high cycle is 3 edges. Throughput is 1 command per 3 cycles.
- Operand read rules:
  - A host write and a command accept on the same edge: the operand reads the OLD register value.
  - A command accepted in the cycle done is high sees the written-back value, so no forwarding is needed.
- lu_a, lu_b and lu_select hold their values outside EXEC until the next accept.
- A host write to a source register during EXEC or WB does not alter the latched operands.
- Host write and write-back to the same address on the same edge: the write-back wins. To different addresses: both apply.
- Host writes are accepted in every state.
- src_a==src_b==dst is legal.
- The logic unit's own reset is driven externally and is out of scope here.

Decomposition:
- Shared package holds:
  - op encoding constants: OP_AND=0, OP_OR=1, OP_XOR=2, OP_NOT=3;
  - state encoding constants: IDLE, EXEC, WB.
- One sub-module: micro_op_regfile. It has a 2-read combinational/1-write port file plus a priority host write port, and implements the write-back-over-host priority rule.

Test Plan:
- Load R0=1100 and R1=1010, then issue op0 a=0 b=1 dst=2 -> done in the 3rd cycle after accept; result=1000; rd_addr=2 reads 1000.
- Same operands with op1, op2 and op3 (op3 dst=3) -> results 1110, 0110, and 0011 in R3; lu_select shows 1/2/3 during EXEC.
- Back-to-back dependency: issue op1 a=2 b=0 dst=2 in the done cycle of the previous write to R2 -> uses the new R2; cmd_ready is low in EXEC and WB.
- Collision: host wr_en addr=2 data=1111 on the WB edge of a command with dst=2 -> R2 holds lu_data; a host write to addr=1 on that edge lands.
- Reset: drive reset=0 during EXEC -> next cycle state IDLE, all registers 0, done stays 0, no write-back.
- cmd_valid held high for 6 cycles -> exactly 2 commands accepted, one at each IDLE edge.

Source files
------------

// File: rtl/micro_op_issue_pkg.sv
// Shared encodings for the micro-op issue stage: logic-unit op codes and FSM states.
package micro_op_issue_pkg;

    // Op select values driven to the logic unit's selective_set input
    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_NOT = 2'd3;

    // Issue FSM: accept in IDLE, let the unit sample in EXEC, write back in WB
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

endpackage

// File: rtl/micro_op_regfile.sv
// Small register file: two combinational operand read ports, one combinational
// debug read port, a host load port and a write-back port. When both write
// ports target the same register on one edge, the write-back value wins.
module micro_op_regfile #(
    parameter int WIDTH = 4,
    parameter int REGS  = 4,
    parameter int AW    = $clog2(REGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    ra_addr,
    output logic [WIDTH-1:0] ra_data,
    input  logic [AW-1:0]    rb_addr,
    output logic [WIDTH-1:0] rb_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             host_en,
    input  logic [AW-1:0]    host_addr,
    input  logic [WIDTH-1:0] host_data,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_addr,
    input  logic [WIDTH-1:0] wb_data
);

    // Current contents of every register, gathered for the read muxes
    logic [WIDTH-1:0] rf_rd [REGS];

    for (genvar gi = 0; gi < REGS; gi++) begin : g_reg
        logic [WIDTH-1:0] reg_q;
        logic [WIDTH-1:0] reg_d;

        // Next value: write-back has priority over a host load to the same register
        always_comb begin
            reg_d = reg_q;
            if (wb_en && (wb_addr == AW'(gi))) begin
                reg_d = wb_data;
            end else if (host_en && (host_addr == AW'(gi))) begin
                reg_d = host_data;
            end
        end

        // Register storage with synchronous active-low clear
        always_ff @(posedge clock) begin
            if (!reset) begin
                reg_q <= '0;
            end else begin
                reg_q <= reg_d;
            end
        end

        assign rf_rd[gi] = reg_q;
    end

    // Reads see the pre-edge contents, so a same-edge host write is not forwarded
    assign ra_data = rf_rd[ra_addr];
    assign rb_data = rf_rd[rb_addr];
    assign rd_data = rf_rd[rd_addr];

endmodule

// File: rtl/micro_op_issue.sv
// Operand-fetch and issue stage for the 4-bit logic microoperation unit.
// Accepts one command per three cycles, presents operands and op select to the
// unit, and writes its registered result back to the destination register.
module micro_op_issue
    import micro_op_issue_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int REGS  = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_op,
    input  logic [$clog2(REGS)-1:0]   cmd_src_a,
    input  logic [$clog2(REGS)-1:0]   cmd_src_b,
    input  logic [$clog2(REGS)-1:0]   cmd_dst,
    input  logic                      wr_en,
    input  logic [$clog2(REGS)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [$clog2(REGS)-1:0]   rd_addr,
    output logic [WIDTH-1:0]          rd_data,
    output logic [1:0]                lu_select,
    output logic [WIDTH-1:0]          lu_a,
    output logic [WIDTH-1:0]          lu_b,
    input  logic [WIDTH-1:0]          lu_data,
    output logic                      done,
    output logic [WIDTH-1:0]          result
);

    localparam int AW = $clog2(REGS);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] lu_a_q, lu_a_d;
    logic [WIDTH-1:0] lu_b_q, lu_b_d;
    logic [1:0]       lu_sel_q, lu_sel_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0] ra_data;
    logic [WIDTH-1:0] rb_data;
    logic             wb_en;

    micro_op_regfile #(
        .WIDTH (WIDTH),
        .REGS  (REGS),
        .AW    (AW)
    ) u_regfile (
        .clock     (clock),
        .reset     (reset),
        .ra_addr   (cmd_src_a),
        .ra_data   (ra_data),
        .rb_addr   (cmd_src_b),
        .rb_data   (rb_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .host_en   (wr_en),
        .host_addr (wr_addr),
        .host_data (wr_data),
        .wb_en     (wb_en),
        .wb_addr   (dst_q),
        .wb_data   (lu_data)
    );

    // Issue FSM next-state: latch operands on accept, wait one edge for the unit, write back
    always_comb begin
        state_d  = state_q;
        lu_a_d   = lu_a_q;
        lu_b_d   = lu_b_q;
        lu_sel_d = lu_sel_q;
        dst_d    = dst_q;
        done_d   = 1'b0;
        result_d = result_q;
        wb_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    // Operand B is fetched even for NOT; the unit ignores it
                    lu_a_d   = ra_data;
                    lu_b_d   = rb_data;
                    lu_sel_d = cmd_op;
                    dst_d    = cmd_dst;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                state_d = WB;
            end
            WB: begin
                wb_en    = 1'b1;
                result_d = lu_data;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Issue FSM state and registered outputs; reset aborts any in-flight command
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            lu_a_q   <= '0;
            lu_b_q   <= '0;
            lu_sel_q <= OP_AND;
            dst_q    <= '0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            lu_a_q   <= lu_a_d;
            lu_b_q   <= lu_b_d;
            lu_sel_q <= lu_sel_d;
            dst_q    <= dst_d;
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign lu_a      = lu_a_q;
    assign lu_b      = lu_b_q;
    assign lu_select = lu_sel_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_micro_op_issue.sv
// Directed bench for micro_op_issue: expected write-back results are queued at
// issue time and checked by a monitor whenever done pulses.
module tb_micro_op_issue;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic [1:0] cmd_src_a = '0;
    logic [1:0] cmd_src_b = '0;
    logic [1:0] cmd_dst = '0;
    logic       wr_en = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [3:0] wr_data = '0;
    logic [1:0] rd_addr = '0;
    logic [3:0] rd_data;
    logic [1:0] lu_select;
    logic [3:0] lu_a;
    logic [3:0] lu_b;
    logic [3:0] lu_data = '0;
    logic       done;
    logic [3:0] result;

    int vectors = 0;
    int miscompares = 0;
    logic [3:0] exp_q [$];

    micro_op_issue #(.WIDTH(4), .REGS(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_src_a (cmd_src_a),
        .cmd_src_b (cmd_src_b),
        .cmd_dst   (cmd_dst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .lu_select (lu_select),
        .lu_a      (lu_a),
        .lu_b      (lu_b),
        .lu_data   (lu_data),
        .done      (done),
        .result    (result)
    );

    always #5 clock = ~clock;

    // Stand-in for the external logic unit: registered result of the selected op
    always @(posedge clock) begin
        case (lu_select)
            2'd0:    lu_data <= lu_a & lu_b;
            2'd1:    lu_data <= lu_a | lu_b;
            2'd2:    lu_data <= lu_a ^ lu_b;
            default: lu_data <= ~lu_a;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clock) begin
        if (done) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got result %0h expected no write-back", result);
            end else begin
                check("wb_result", {28'd0, result}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input logic [1:0] addr, input logic [3:0] data);
        wr_en = 1'b1;
        wr_addr = addr;
        wr_data = data;
        step();
        wr_en = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [1:0] addr, input logic [3:0] exp);
        rd_addr = addr;
        #1;
        check(name, {28'd0, rd_data}, {28'd0, exp});
    endtask

    // hw_phase: 0 none, 1 host write on the accept edge, 2 host write on the WB edge
    task automatic issue(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] d, input logic [3:0] exp_a, input logic [3:0] exp_b,
                         input logic [3:0] exp_res, input int hw_phase,
                         input logic [1:0] hw_addr, input logic [3:0] hw_data);
        check("ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_dst = d;
        exp_q.push_back(exp_res);
        if (hw_phase == 1) begin
            wr_en = 1'b1; wr_addr = hw_addr; wr_data = hw_data;
        end
        step();
        cmd_valid = 1'b0;
        wr_en = 1'b0;
        // EXEC cycle
        check("exec_select", {30'd0, lu_select}, {30'd0, op});
        check("exec_lu_a", {28'd0, lu_a}, {28'd0, exp_a});
        check("exec_lu_b", {28'd0, lu_b}, {28'd0, exp_b});
        check("exec_ready", {31'd0, cmd_ready}, 32'd0);
        check("exec_done", {31'd0, done}, 32'd0);
        step();
        // WB cycle
        check("wb_ready", {31'd0, cmd_ready}, 32'd0);
        check("wb_done", {31'd0, done}, 32'd0);
        if (hw_phase == 2) begin
            wr_en = 1'b1; wr_addr = hw_addr; wr_data = hw_data;
        end
        step();
        wr_en = 1'b0;
        // Done cycle: third edge after accept
        check("done_latency", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int accepts;
        // Reset state
        step();
        step();
        check("rst_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {28'd0, result}, 32'd0);
        check("rst_lu_a", {28'd0, lu_a}, 32'd0);
        check("rst_lu_sel", {30'd0, lu_select}, 32'd0);
        for (int i = 0; i < 4; i++) read_check("rst_reg", 2'(i), 4'h0);
        reset = 1'b1;
        step();

        load(2'd0, 4'b1100);
        load(2'd1, 4'b1010);

        // Basic ops
        issue(2'd0, 2'd0, 2'd1, 2'd2, 4'hC, 4'hA, 4'b1000, 0, 2'd0, 4'h0);
        read_check("r2_and", 2'd2, 4'b1000);
        issue(2'd1, 2'd0, 2'd1, 2'd2, 4'hC, 4'hA, 4'b1110, 0, 2'd0, 4'h0);
        issue(2'd2, 2'd0, 2'd1, 2'd2, 4'hC, 4'hA, 4'b0110, 0, 2'd0, 4'h0);
        issue(2'd3, 2'd0, 2'd1, 2'd3, 4'hC, 4'hA, 4'b0011, 0, 2'd0, 4'h0);
        read_check("r3_not", 2'd3, 4'b0011);

        // Back-to-back dependency: second accept in the done cycle sees new R2
        issue(2'd0, 2'd0, 2'd1, 2'd2, 4'hC, 4'hA, 4'b1000, 0, 2'd0, 4'h0);
        issue(2'd1, 2'd2, 2'd0, 2'd2, 4'b1000, 4'hC, 4'b1100, 0, 2'd0, 4'h0);
        read_check("r2_dep", 2'd2, 4'b1100);

        // Host write vs write-back, same address: write-back wins
        issue(2'd2, 2'd0, 2'd1, 2'd2, 4'hC, 4'hA, 4'b0110, 2, 2'd2, 4'b1111);
        read_check("r2_collide", 2'd2, 4'b0110);
        // Different addresses: both land
        issue(2'd0, 2'd0, 2'd1, 2'd2, 4'hC, 4'hA, 4'b1000, 2, 2'd1, 4'b0101);
        read_check("r2_both", 2'd2, 4'b1000);
        read_check("r1_both", 2'd1, 4'b0101);
        // Host write on the accept edge: operands use the old value
        issue(2'd1, 2'd1, 2'd1, 2'd3, 4'b0101, 4'b0101, 4'b0101, 1, 2'd1, 4'b0011);
        read_check("r1_new", 2'd1, 4'b0011);
        read_check("r3_old_op", 2'd3, 4'b0101);

        // Reset during EXEC aborts the command
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_src_a = 2'd0; cmd_src_b = 2'd1; cmd_dst = 2'd0;
        step();
        cmd_valid = 1'b0;
        reset = 1'b0;
        step();
        check("abort_ready", {31'd0, cmd_ready}, 32'd1);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_lu_a", {28'd0, lu_a}, 32'd0);
        check("abort_lu_b", {28'd0, lu_b}, 32'd0);
        check("abort_result", {28'd0, result}, 32'd0);
        for (int i = 0; i < 4; i++) read_check("abort_reg", 2'(i), 4'h0);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check("abort_no_wb", {28'd0, rd_data}, 32'd0);

        // cmd_valid held high for six edges: exactly two accepts
        load(2'd0, 4'b1100);
        load(2'd1, 4'b1010);
        accepts = 0;
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_src_a = 2'd0; cmd_src_b = 2'd1; cmd_dst = 2'd3;
        exp_q.push_back(4'b1000);
        exp_q.push_back(4'b1000);
        for (int i = 0; i < 6; i++) begin
            if (cmd_ready) accepts++;
            step();
        end
        cmd_valid = 1'b0;
        check("held_accepts", 32'(accepts), 32'd2);
        step();
        step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        read_check("r3_held", 2'd3, 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
